// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: 1 start, 8 data LSB first, 1 stop; 2-flop synchronizer, mid-bit sampling.
// Defining UART_RX_PARITY_EN adds an even-parity bit before the stop bit and the out_fParityErr strobe.
module uart_rx #(
  parameter int KBAUD = 10416
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_DataBit,
  output logic [7:0] out_DataByte,
  output logic       out_fValid,
  output logic       out_fFrameErr,
`ifdef UART_RX_PARITY_EN
  output logic       out_fParityErr,
`endif
  output logic       out_fBusy
);
  localparam int CW = $clog2(KBAUD);
  localparam logic [CW-1:0] HALF_LOAD = CW'(KBAUD / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(KBAUD - 1);

  typedef enum logic [2:0] {
    s_IDLE  = 3'd0,
    s_START = 3'd1,
    s_DATA  = 3'd2,
    s_STOP  = 3'd3,
    s_WAIT  = 3'd4
`ifdef UART_RX_PARITY_EN
    , s_PARITY = 3'd5
`endif
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, rx_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    byte_q, byte_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          tick;
`ifdef UART_RX_PARITY_EN
  logic          par_q, par_d;
  logic          perr_q, perr_d;
`endif

  assign tick = (cnt_q == '0);

  // The synchronizer resets high so a line held low through reset reads as a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= in_DataBit;
      rx_s_q  <= sync1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= s_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      s_IDLE:  if (!rx_s_q) state_d = s_START;
      s_START: if (tick) state_d = rx_s_q ? s_IDLE : s_DATA;
`ifdef UART_RX_PARITY_EN
      s_DATA:   if (tick && bit_q == 3'd7) state_d = s_PARITY;
      s_PARITY: if (tick) state_d = s_STOP;
`else
      s_DATA:  if (tick && bit_q == 3'd7) state_d = s_STOP;
`endif
      s_STOP:  if (tick) state_d = rx_s_q ? s_IDLE : s_WAIT;
      s_WAIT:  if (rx_s_q) state_d = s_IDLE;
      default: state_d = s_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = tick ? cnt_q : cnt_q - CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      s_IDLE: if (!rx_s_q) cnt_d = HALF_LOAD;
      s_START: begin
        if (tick && !rx_s_q) begin
          cnt_d = FULL_LOAD;
          bit_d = 3'd0;
        end
      end
      s_DATA: begin
        if (tick) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          cnt_d   = FULL_LOAD;
        end
      end
`ifdef UART_RX_PARITY_EN
      s_PARITY: begin
        if (tick) begin
          par_d = rx_s_q;
          cnt_d = FULL_LOAD;
        end
      end
`endif
      s_STOP: begin
        if (tick) begin
`ifdef UART_RX_PARITY_EN
          perr_d = ^{shift_q, par_q};
          if (rx_s_q && !perr_d) begin
`else
          if (rx_s_q) begin
`endif
            byte_d  = shift_q;
            valid_d = 1'b1;
          end
          ferr_d = !rx_s_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      byte_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign out_DataByte  = byte_q;
  assign out_fValid    = valid_q;
  assign out_fFrameErr = ferr_q;
  assign out_fBusy     = (state_q != s_IDLE);
`ifdef UART_RX_PARITY_EN
  assign out_fParityErr = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx at KBAUD=16 (table vectors, random frames, corner sequences).
// Parity checks are included when UART_RX_PARITY_EN is defined.
module tb_uart_rx;
  localparam int KB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_DataBit = 1'b1;
  logic [7:0] out_DataByte;
  logic       out_fValid;
  logic       out_fFrameErr;
  logic       out_fBusy;
  logic       perr_w;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t_start = 0;
  int t_valid = 0;
  bit prev_strobe = 1'b0;

  // kind: 0 = good byte, 1 = framing error, 2 = parity error
  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;
  ev_t obs[$];

  typedef struct {
    logic [7:0] data;
    bit         stop;
    int         gap;
    int         exp_kind;
    logic [7:0] exp_byte;
  } vec_t;
  vec_t vt[8];

  uart_rx #(.KBAUD(KB)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_DataBit   (in_DataBit),
    .out_DataByte (out_DataByte),
    .out_fValid   (out_fValid),
    .out_fFrameErr(out_fFrameErr),
`ifdef UART_RX_PARITY_EN
    .out_fParityErr(perr_w),
`endif
    .out_fBusy    (out_fBusy)
  );

`ifndef UART_RX_PARITY_EN
  assign perr_w = 1'b0;
`else
  bit par_bad = 1'b0;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    bit strobe;
    if (rst) begin
      prev_strobe = 1'b0;
    end else begin
      strobe = out_fValid || out_fFrameErr || perr_w;
      if (strobe) begin
        total++;
        if (out_fValid && out_fFrameErr) begin
          bad++;
          $display("FAIL strobe_excl valid=%0b ferr=%0b required not both high", out_fValid, out_fFrameErr);
        end
        total++;
        if (prev_strobe) begin
          bad++;
          $display("FAIL strobe_consec strobe high two cycles in a row, required single-cycle pulse");
        end
        if (out_fValid) begin
          obs.push_back('{0, out_DataByte});
          t_valid = cyc;
        end
        if (out_fFrameErr) obs.push_back('{1, 8'h00});
        if (perr_w) obs.push_back('{2, 8'h00});
      end
      prev_strobe = strobe;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic b, input int n);
    in_DataBit = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop);
    t_start = cyc;
    drive(1'b0, KB);
    for (int i = 0; i < 8; i++) drive(d[i], KB);
`ifdef UART_RX_PARITY_EN
    drive((^d) ^ par_bad, KB);
`endif
    drive(stop, KB);
  endtask

  task automatic check_frame(input string name, input int kind, input logic [7:0] data,
                             input logic [7:0] hold);
    ev_t e;
    chk({name, "_present"}, obs.size() > 0 ? 1 : 0, 1);
    if (obs.size() > 0) begin
      e = obs.pop_front();
      chk({name, "_kind"}, e.kind, kind);
      if (kind == 0) chk({name, "_data"}, int'(e.data), int'(data));
    end
    chk({name, "_held_byte"}, int'(out_DataByte), int'(hold));
  endtask

  initial begin
    int          busy_cnt;
    int          lat;
    logic [7:0]  last_good;
    logic [7:0]  d;
    logic [7:0]  r81;
    bit          stop;
    int          gap;

    vt[0] = '{8'hA5, 1'b1, 0,  0, 8'hA5};
    vt[1] = '{8'h00, 1'b1, 0,  0, 8'h00};
    vt[2] = '{8'hFF, 1'b1, 0,  0, 8'hFF};
    vt[3] = '{8'h55, 1'b1, 10, 0, 8'h55};
    vt[4] = '{8'h3C, 1'b0, 20, 1, 8'h55};
    vt[5] = '{8'h01, 1'b1, 0,  0, 8'h01};
    vt[6] = '{8'h80, 1'b1, 5,  0, 8'h80};
    vt[7] = '{8'hC3, 1'b0, 20, 1, 8'h80};

    repeat (3) @(negedge clk);
    chk("rst_byte", int'(out_DataByte), 0);
    chk("rst_valid", int'(out_fValid), 0);
    chk("rst_ferr", int'(out_fFrameErr), 0);
    chk("rst_busy", int'(out_fBusy), 0);
    rst = 1'b0;

    busy_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (out_fBusy) busy_cnt++;
    end
    chk("idle_busy_cycles", busy_cnt, 0);
    chk("idle_events", obs.size(), 0);
    chk("idle_byte", int'(out_DataByte), 0);

    drive(1'b0, 5);
    in_DataBit = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_fBusy) busy_cnt++;
    end
    chk("glitch_detected", busy_cnt > 0 ? 1 : 0, 1);
    chk("glitch_busy_short", busy_cnt <= 9 ? 1 : 0, 1);
    chk("glitch_busy_end", int'(out_fBusy), 0);
    chk("glitch_events", obs.size(), 0);

    for (int i = 0; i < 8; i++) begin
      send_frame(vt[i].data, vt[i].stop);
      check_frame($sformatf("vec%0d", i), vt[i].exp_kind, vt[i].data, vt[i].exp_byte);
      if (i == 0) begin
        lat = t_valid - t_start;
        total++;
        if (lat < 154 || lat > 156) begin
          bad++;
          $display("FAIL latency actual=%0d required=154..156", lat);
        end
      end
      if (!vt[i].stop) drive(1'b0, 40);
      drive(1'b1, vt[i].gap);
      if (vt[i].gap > 0) chk($sformatf("vec%0d_quiet", i), obs.size(), 0);
    end

    last_good = 8'h80;
    for (int n = 0; n < 24; n++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      gap  = stop ? int'($urandom_range(0, 30)) : 20;
      send_frame(d, stop);
      if (stop) last_good = d;
      check_frame($sformatf("rnd%0d", n), stop ? 0 : 1, d, last_good);
      if (!stop) drive(1'b0, int'($urandom_range(0, 40)));
      drive(1'b1, gap);
      if (gap > 0) chk($sformatf("rnd%0d_quiet", n), obs.size(), 0);
    end

    r81 = 8'h81;
    drive(1'b0, KB);
    for (int i = 0; i < 4; i++) drive(r81[i], KB);
    drive(r81[4], 8);
    rst = 1'b1;
    in_DataBit = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_busy", int'(out_fBusy), 0);
    chk("midrst_byte", int'(out_DataByte), 0);
    rst = 1'b0;
    drive(1'b1, 40);
    chk("midrst_no_strobe", obs.size(), 0);
    send_frame(8'h7E, 1'b1);
    check_frame("after_rst", 0, 8'h7E, 8'h7E);
    drive(1'b1, 10);

`ifdef UART_RX_PARITY_EN
    par_bad = 1'b1;
    send_frame(8'h7E ^ 8'h01, 1'b1);
    par_bad = 1'b0;
    check_frame("parity_bad", 2, 8'h00, 8'h7E);
    drive(1'b1, 10);
    chk("parity_no_valid", obs.size(), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver; counterpart of the team's UART transmitter. Same frame format: 1 start bit (low), 8 data bits LSB first, 1 stop bit (high), idle line high.
- Converts the serial line into bytes with a one-cycle valid strobe and a framing-error strobe.
- Sits between the board RX pin and byte-level consumers (command parsers, FIFOs).
- Bit period is a fixed clock count set by parameter, matching the transmitter's KBAUD convention.

Parameters:
- KBAUD, 10416, clock cycles per bit (e.g. 100 MHz / 9600 Bd). Must be ≥ 4. Counter width is $clog2(KBAUD).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, asynchronous and active-high.
- in_DataBit  input  1  serial line from pin; asynchronous to clk, idles high.
- out_DataByte  output  8  last correctly received byte; holds until the next good frame.
- out_fValid  output  1  one-cycle pulse: out_DataByte updated this cycle.
- out_fFrameErr  output  1  one-cycle pulse: stop bit sampled low.
- out_fBusy  output  1  high from start-bit detection until return to s_IDLE.

Behaviour:
- Reset values:
  - out_DataByte=0, out_fValid=0, out_fFrameErr=0, out_fBusy=0.
  - State s_IDLE; baud counter and bit counter = 0; shift register = 0.
  - Both synchronizer flops = 1.
- Synchronizer: in_DataBit passes through 2 flops. All decisions use the second flop (rx_s). There is no other filtering.
- Baud counter: down-counter. An event fires when it reaches 0.
- s_IDLE:
  - out_fBusy=0.
  - If rx_s==0: load counter with KBAUD/2-1 (integer division), set out_fBusy=1, go to s_START.
- s_START (mid start bit):
  - At counter 0, re-sample rx_s.
  - If rx_s==1: false start. Go to s_IDLE, no strobes.
  - Else: load KBAUD-1, bit counter=0, go to s_DATA.
- s_DATA:
  - At each counter 0, shift rx_s into the MSB of the shift register (right-shift, so first bit ends in bit 0). Increment bit counter. Reload KBAUD-1.
  - After the 8th sample (bit counter==7 at the event), go to s_STOP.
- s_STOP (mid stop bit), at counter 0:
  - If rx_s==1: out_DataByte<=shift register, out_fValid=1 for exactly one cycle, go to s_IDLE immediately. A back-to-back start edge half a bit later must be caught.
  - If rx_s==0: out_fFrameErr=1 for one cycle, out_DataByte unchanged, go to s_WAIT.
- s_WAIT (break or framing error): stay until rx_s==1, then go to s_IDLE. A held-low line must not produce repeated frames.
- out_fValid and out_fFrameErr are never both high and never high for two consecutive cycles.
- Latency: first out_fValid occurs KBAUD/2 + 9*KBAUD + 3 cycles (±1) after the falling edge on in_DataBit.
- Reset mid-frame: immediate return to the reset state. A partial byte is discarded with no strobe. After reset is released, a line still low is treated as a start edge (the synchronizer resets high).
- No overrun handling: the consumer must take out_DataByte within one frame time.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - Frame carries an even-parity bit between bit 7 and the stop bit. State s_PARITY samples it one KBAUD after the last data bit.
  - Adds output out_fParityErr (1 bit, reset 0). It pulses one cycle, coincident with the s_STOP evaluation, when the XOR of the 8 data bits and the parity bit is 1.
  - On parity error with a good stop bit: out_fValid stays 0 and out_DataByte is not updated.
  - Latency grows by KBAUD.
- When undefined: no s_PARITY state and no out_fParityErr port. Frame is exactly 10 bits.

Test Plan (KBAUD=16 unless noted):
- Reset then idle: line held high for 1000 cycles → no strobes, out_fBusy=0, out_DataByte=0x00.
- Single frame 0xA5, driven LSB first at 16 cycles/bit → one out_fValid pulse about 155 cycles after the start edge, out_DataByte=0xA5, out_fFrameErr never high.
- Back-to-back 0x00, 0xFF, 0x55 with no idle gap → exactly three out_fValid pulses, bytes in order, no framing errors.
- Glitch: line low for 5 cycles then high → no strobes, out_fBusy returns to 0 within 8 cycles of start-bit detection.
- Stop bit forced low on 0x3C, line held low 40 more cycles then released → one out_fFrameErr pulse, out_DataByte keeps the previous value, no further strobes until the next valid frame, which is received correctly.
- rst asserted at data bit 4 of 0x81, then a clean 0x7E sent → no strobe for 0x81, out_DataByte=0x7E. With UART_RX_PARITY_EN: 0x7E with wrong parity → out_fParityErr pulse and no out_fValid.
